spi_shift_in: RTL and testbench
===============================

# spi_shift_in

Serial-to-parallel SPI receive shift register, the inbound counterpart of the SPI shift-out path. It samples serial data MSB first on the rising edge of the SPI clock and assembles DEPTH-bit words. Each completed word is transferred into a holding register and presented to the parallel consumer with an active-low ready / active-high acknowledge handshake. It sits between the SPI pins (Sdi, CsN) and the CPLD register/FIFO logic, all in the SPI_Clk domain.

## Interface

Parameters:
- DEPTH, 8, word width in bits; the counter is wide enough for 0..DEPTH-1.

Ports:
- SPI_Clk  in  1  sole clock; all state updates on rising edge.
- SPI_Reset  in  1  reset; one clock, reset is synchronous and active-high.
- SPI_CsN  in  1  frame select, active low; high = idle / frame abort.
- SPI_Sdi  in  1  serial data in, MSB first.
- SPI_Data_Out  out  DEPTH  holding register, last accepted word.
- SPI_Data_RdyN  out  1  low = SPI_Data_Out valid and unacknowledged.
- SPI_DataAck  in  1  consumer acknowledge, high for one clock.
- SPI_Overrun  out  1  sticky: a completed word was dropped.
- SPI_Overrun_Clr  in  1  clears SPI_Overrun.

## Operation

- State: shift register sr[DEPTH-1:0], bit counter cnt, holding register, valid flag (SPI_Data_RdyN = ~valid), overrun flag.
- Shift phase, SPI_CsN low: each edge sr <= {sr[DEPTH-2:0], SPI_Sdi}; cnt increments.
- Completion: edge where SPI_CsN low and cnt == DEPTH-1. The word is {sr[DEPTH-2:0], SPI_Sdi}. cnt wraps to 0. Back-to-back words need no gap clocks.
- Idle / abort, SPI_CsN high: cnt <= 0 and sr holds. A partial word is discarded and not reported.
- Transfer on completion:
  - valid low, or SPI_DataAck high in the same cycle: holding <= word and valid <= 1.
  - Otherwise: word dropped, holding unchanged, SPI_Overrun <= 1.
- SPI_DataAck with no completion: valid <= 0. Ack while valid is already 0 is ignored.
- SPI_Overrun_Clr: SPI_Overrun <= 0. If a clear and a new overrun fall on the same edge, set wins.
- Synchronous reset:
  - sr = all ones, cnt = 0.
  - SPI_Data_Out = all ones, SPI_Data_RdyN = 1, SPI_Overrun = 0.
  - Reset overrides all inputs, including mid-word; the partial word is lost.

## Timing

- Latency: SPI_Data_Out and SPI_Data_RdyN update on the same edge that samples the final (LSB) bit. That is DEPTH edges after the first bit, counted from cnt = 0.
- SPI_Data_RdyN falls registered, with no combinational path from SPI_Sdi.
- Ack to RdyN high: 1 edge.
- Consumer window per word: DEPTH-1 clocks after RdyN falls at continuous clocking. An ack on the completion edge of the next word still avoids overrun.
- SPI_CsN is sampled on the rising edge. Its setup is to that edge, and it takes effect on the same edge.
- All outputs are registered.

## Configuration

- SPI_IDLE_FILTER_EN defined:
  - A completed word equal to all ones (idle fill from the shift-out side) is discarded.
  - No holding-register load, no valid change, no overrun set.
  - Counter behaviour is unchanged.
- Undefined: every completed word is delivered, all-ones included.

## Test plan

- Reset, then SPI_CsN low and shift 0xA5 MSB first. Required: after the 8th edge, SPI_Data_Out = 0xA5 and SPI_Data_RdyN = 0. Pulse ack: RdyN = 1 on the next edge.
- Abort mid-word: shift 3 bits of 0x3C, raise SPI_CsN for 2 clocks, lower it and shift 0x96. Required: a single word 0x96, no overrun.
- Back-to-back 0x12 then 0x34 with no ack. Required: SPI_Data_Out stays 0x12 and SPI_Overrun = 1. Then apply ack and clear together with the next word 0x56. Required: Out = 0x56, Overrun = 0.
- Ack on the completion edge of the second word (0x12, then 0x34). Required: Out = 0x34, RdyN = 0, SPI_Overrun = 0.
- Shift 0xFF then 0x5A.
  - With SPI_IDLE_FILTER_EN: only 0x5A is delivered.
  - Without it: 0xFF is delivered first.
- Assert SPI_Reset at bit 5 of a word. Required: RdyN = 1, Out = 0xFF, Overrun = 0. The next full word 0xC3 is received correctly.

Source files
------------

// File: rtl/spi_shift_in_if.sv
// Parallel-side and pin-side signals of the SPI receive shift register.
// master drives the pins, ack and clear; slave is the shift-in block.
interface spi_shift_in_if #(
  parameter int DEPTH = 8
);
  logic             SPI_CsN;
  logic             SPI_Sdi;
  logic [DEPTH-1:0] SPI_Data_Out;
  logic             SPI_Data_RdyN;
  logic             SPI_DataAck;
  logic             SPI_Overrun;
  logic             SPI_Overrun_Clr;

  modport master (
    output SPI_CsN, SPI_Sdi, SPI_DataAck, SPI_Overrun_Clr,
    input  SPI_Data_Out, SPI_Data_RdyN, SPI_Overrun
  );

  modport slave (
    input  SPI_CsN, SPI_Sdi, SPI_DataAck, SPI_Overrun_Clr,
    output SPI_Data_Out, SPI_Data_RdyN, SPI_Overrun
  );
endinterface

// File: rtl/spi_shift_in.sv
// SPI MSB-first serial-to-parallel receiver; word lands on the edge sampling its LSB, RdyN/ack handshake,
// unacked word + new word = drop and sticky overrun. SPI_IDLE_FILTER_EN discards all-ones words.
module spi_shift_in #(
  parameter int DEPTH = 8
) (
  input  logic           SPI_Clk,
  input  logic           SPI_Reset,
  spi_shift_in_if.slave  bus
);
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Only DEPTH-1 bits are kept: the oldest bit is never part of the next word.
  logic [DEPTH-2:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] hold_q, hold_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;

  logic [DEPTH-1:0] word;
  logic             done;
  logic             deliver;
  logic             ovr_set;

  always_comb begin
    word    = {sr_q, bus.SPI_Sdi};
    done    = ~bus.SPI_CsN && (cnt_q == CW'(DEPTH - 1));
    deliver = done;
`ifdef SPI_IDLE_FILTER_EN
    if (word == '1) deliver = 1'b0;
`endif
    sr_d    = sr_q;
    cnt_d   = '0;
    hold_d  = hold_q;
    vld_d   = vld_q;
    ovr_set = 1'b0;

    if (!bus.SPI_CsN) begin
      sr_d  = word[DEPTH-2:0];
      cnt_d = done ? '0 : cnt_q + CW'(1);
    end

    if (deliver) begin
      if (!vld_q || bus.SPI_DataAck) begin
        hold_d = word;
        vld_d  = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (bus.SPI_DataAck) begin
      vld_d = 1'b0;
    end

    // Set beats clear when both land on the same edge.
    ovr_d = ovr_q;
    if (bus.SPI_Overrun_Clr) ovr_d = 1'b0;
    if (ovr_set)             ovr_d = 1'b1;
  end

  always_ff @(posedge SPI_Clk) begin
    if (SPI_Reset) begin
      sr_q   <= '1;
      cnt_q  <= '0;
      hold_q <= '1;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
    end
  end

  assign bus.SPI_Data_Out  = hold_q;
  assign bus.SPI_Data_RdyN = ~vld_q;
  assign bus.SPI_Overrun   = ovr_q;
endmodule

// File: tb/tb_spi_shift_in.sv
// Randomised and directed bench for spi_shift_in against a word-level reference model.
module tb_spi_shift_in;
  localparam int DEPTH = 8;

  logic SPI_Clk = 1'b0;
  logic SPI_Reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: bit count plus accumulated value, word-level delivery rules.
  int         m_acc;
  int         m_n;
  logic [7:0] m_out;
  logic       m_vld;
  logic       m_ovr;

  spi_shift_in_if #(.DEPTH(DEPTH)) ifc ();

  spi_shift_in #(.DEPTH(DEPTH)) dut (
    .SPI_Clk   (SPI_Clk),
    .SPI_Reset (SPI_Reset),
    .bus       (ifc)
  );

  always #5 SPI_Clk = ~SPI_Clk;

  task automatic m_step(input logic csn, input logic sdi, input logic ack, input logic clr, input logic rst);
    bit comp, dlv, oset;
    if (rst) begin
      m_acc = 0; m_n = 0; m_out = 8'hFF; m_vld = 1'b0; m_ovr = 1'b0;
      return;
    end
    comp = 0; oset = 0;
    if (!csn) begin
      m_acc = (m_acc * 2 + int'(sdi)) % 256;
      m_n++;
      if (m_n == DEPTH) begin comp = 1; m_n = 0; end
    end else begin
      m_n = 0;
    end
    dlv = comp;
`ifdef SPI_IDLE_FILTER_EN
    if (comp && m_acc == 255) dlv = 0;
`endif
    if (dlv) begin
      if (!m_vld || ack) begin m_out = 8'(m_acc); m_vld = 1'b1; end
      else oset = 1;
    end else if (ack) begin
      m_vld = 1'b0;
    end
    if (clr)  m_ovr = 1'b0;
    if (oset) m_ovr = 1'b1;
  endtask

  task automatic step(input logic csn, input logic sdi, input logic ack, input logic clr, input logic rst);
    ifc.SPI_CsN = csn; ifc.SPI_Sdi = sdi; ifc.SPI_DataAck = ack;
    ifc.SPI_Overrun_Clr = clr; SPI_Reset = rst;
    m_step(csn, sdi, ack, clr, rst);
    @(posedge SPI_Clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic ack_last, input logic clr_last);
    for (int i = DEPTH - 1; i >= 0; i--)
      step(1'b0, w[i], (i == 0) ? ack_last : 1'b0, (i == 0) ? clr_last : 1'b0, 1'b0);
  endtask

  task automatic idle_ack();
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ifc.SPI_Data_Out !== 8'hFF) begin n_fail++; $display("FAIL reset_out got %h want ff", ifc.SPI_Data_Out); end
    n_checks++;
    if (ifc.SPI_Data_RdyN !== 1'b1) begin n_fail++; $display("FAIL reset_rdyn got %b want 1", ifc.SPI_Data_RdyN); end
    n_checks++;
    if (ifc.SPI_Overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got %b want 0", ifc.SPI_Overrun); end
  endtask

  task automatic test_basic();
    for (int i = DEPTH - 1; i >= 1; i--) step(1'b0, 8'hA5 >> i, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ifc.SPI_Data_RdyN !== 1'b1) begin n_fail++; $display("FAIL basic_early_rdyn got %b want 1", ifc.SPI_Data_RdyN); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ifc.SPI_Data_Out !== 8'hA5) begin n_fail++; $display("FAIL basic_out got %h want a5", ifc.SPI_Data_Out); end
    n_checks++;
    if (ifc.SPI_Data_RdyN !== 1'b0) begin n_fail++; $display("FAIL basic_rdyn got %b want 0", ifc.SPI_Data_RdyN); end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (ifc.SPI_Data_RdyN !== 1'b1) begin n_fail++; $display("FAIL basic_ack_rdyn got %b want 1", ifc.SPI_Data_RdyN); end
  endtask

  task automatic test_abort();
    logic [7:0] p;
    p = 8'h3C;
    for (int i = 7; i >= 5; i--) step(1'b0, p[i], 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ifc.SPI_Data_RdyN !== 1'b1) begin n_fail++; $display("FAIL abort_partial_rdyn got %b want 1", ifc.SPI_Data_RdyN); end
    send_word(8'h96, 1'b0, 1'b0);
    n_checks++;
    if (ifc.SPI_Data_Out !== 8'h96) begin n_fail++; $display("FAIL abort_out got %h want 96", ifc.SPI_Data_Out); end
    n_checks++;
    if (ifc.SPI_Overrun !== 1'b0) begin n_fail++; $display("FAIL abort_ovr got %b want 0", ifc.SPI_Overrun); end
    idle_ack();
  endtask

  task automatic test_overrun();
    send_word(8'h12, 1'b0, 1'b0);
    send_word(8'h34, 1'b0, 1'b0);
    n_checks++;
    if (ifc.SPI_Data_Out !== 8'h12) begin n_fail++; $display("FAIL ovr_out got %h want 12", ifc.SPI_Data_Out); end
    n_checks++;
    if (ifc.SPI_Overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b want 1", ifc.SPI_Overrun); end
    send_word(8'h56, 1'b1, 1'b1);
    n_checks++;
    if (ifc.SPI_Data_Out !== 8'h56) begin n_fail++; $display("FAIL ovr_recover_out got %h want 56", ifc.SPI_Data_Out); end
    n_checks++;
    if (ifc.SPI_Overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_recover_flag got %b want 0", ifc.SPI_Overrun); end
    idle_ack();
  endtask

  task automatic test_back_to_back();
    send_word(8'h12, 1'b0, 1'b0);
    send_word(8'h34, 1'b1, 1'b0);
    n_checks++;
    if (ifc.SPI_Data_Out !== 8'h34) begin n_fail++; $display("FAIL b2b_out got %h want 34", ifc.SPI_Data_Out); end
    n_checks++;
    if (ifc.SPI_Data_RdyN !== 1'b0) begin n_fail++; $display("FAIL b2b_rdyn got %b want 0", ifc.SPI_Data_RdyN); end
    n_checks++;
    if (ifc.SPI_Overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_ovr got %b want 0", ifc.SPI_Overrun); end
    idle_ack();
  endtask

  task automatic test_idle_filter();
    send_word(8'hFF, 1'b0, 1'b0);
`ifdef SPI_IDLE_FILTER_EN
    n_checks++;
    if (ifc.SPI_Data_RdyN !== 1'b1) begin n_fail++; $display("FAIL idle_ff_rdyn got %b want 1", ifc.SPI_Data_RdyN); end
    n_checks++;
    if (ifc.SPI_Data_Out !== 8'h34) begin n_fail++; $display("FAIL idle_ff_out got %h want 34", ifc.SPI_Data_Out); end
`else
    n_checks++;
    if (ifc.SPI_Data_RdyN !== 1'b0) begin n_fail++; $display("FAIL idle_ff_rdyn got %b want 0", ifc.SPI_Data_RdyN); end
    n_checks++;
    if (ifc.SPI_Data_Out !== 8'hFF) begin n_fail++; $display("FAIL idle_ff_out got %h want ff", ifc.SPI_Data_Out); end
`endif
    idle_ack();
    send_word(8'h5A, 1'b0, 1'b0);
    n_checks++;
    if (ifc.SPI_Data_Out !== 8'h5A) begin n_fail++; $display("FAIL idle_5a_out got %h want 5a", ifc.SPI_Data_Out); end
    n_checks++;
    if (ifc.SPI_Overrun !== 1'b0) begin n_fail++; $display("FAIL idle_5a_ovr got %b want 0", ifc.SPI_Overrun); end
    idle_ack();
  endtask

  task automatic test_reset_midword();
    logic [7:0] p;
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    p = 8'hC3;
    for (int i = 7; i >= 4; i--) step(1'b0, p[i], 1'b0, 1'b0, 1'b0);
    step(1'b0, p[3], 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (ifc.SPI_Data_RdyN !== 1'b1) begin n_fail++; $display("FAIL midrst_rdyn got %b want 1", ifc.SPI_Data_RdyN); end
    n_checks++;
    if (ifc.SPI_Data_Out !== 8'hFF) begin n_fail++; $display("FAIL midrst_out got %h want ff", ifc.SPI_Data_Out); end
    n_checks++;
    if (ifc.SPI_Overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_ovr got %b want 0", ifc.SPI_Overrun); end
    send_word(8'hC3, 1'b0, 1'b0);
    n_checks++;
    if (ifc.SPI_Data_Out !== 8'hC3) begin n_fail++; $display("FAIL midrst_next_out got %h want c3", ifc.SPI_Data_Out); end
    n_checks++;
    if (ifc.SPI_Data_RdyN !== 1'b0) begin n_fail++; $display("FAIL midrst_next_rdyn got %b want 0", ifc.SPI_Data_RdyN); end
    idle_ack();
  endtask

  task automatic test_random();
    logic csn, sdi, ack, clr, rst;
    for (int k = 0; k < 600; k++) begin
      csn = ($urandom_range(0, 9) == 0);
      sdi = 1'($urandom_range(0, 1));
      ack = ($urandom_range(0, 5) == 0);
      clr = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step(csn, sdi, ack, clr, rst);
      n_checks++;
      if (ifc.SPI_Data_Out !== m_out || ifc.SPI_Data_RdyN !== ~m_vld || ifc.SPI_Overrun !== m_ovr) begin
        n_fail++;
        $display("FAIL random step %0d got out=%h rdyn=%b ovr=%b want out=%h rdyn=%b ovr=%b",
                 k, ifc.SPI_Data_Out, ifc.SPI_Data_RdyN, ifc.SPI_Overrun, m_out, ~m_vld, m_ovr);
      end
    end
  endtask

  initial begin
    ifc.SPI_CsN = 1'b1; ifc.SPI_Sdi = 1'b0; ifc.SPI_DataAck = 1'b0;
    ifc.SPI_Overrun_Clr = 1'b0; SPI_Reset = 1'b1;
    m_acc = 0; m_n = 0; m_out = 8'hFF; m_vld = 1'b0; m_ovr = 1'b0;
    test_reset();
    test_basic();
    test_abort();
    test_overrun();
    test_back_to_back();
    test_idle_filter();
    test_reset_midword();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
